// File: rtl/i2s_sample_capture.sv
// I2S receiver front end: synchronises BCLK/LRCK/SDATA, deserialises one channel
// into a DATA_WIDTH-bit word and holds it on a stable parallel bus for the PIO.
module i2s_sample_capture #(
    parameter int DATA_WIDTH  = 24,
    parameter int CHANNEL     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  bclk,
    input  logic                  lrck,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sample_valid,
    output logic [15:0]           sample_count,
    output logic                  short_frame_err,
    input  logic                  clear_err
);

    localparam int              CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic            CHAN_LRCK = (CHANNEL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_r;
    logic [SYNC_STAGES-1:0] lrck_sync_r;
    logic [SYNC_STAGES-1:0] sdata_sync_r;
    logic                   bclk_d_r;
    logic                   lrck_prev_r;
    state_t                 state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [DATA_WIDTH-1:0]  shift_r;

    logic                   bclk_s;
    logic                   lrck_s;
    logic                   sdata_s;
    logic                   bclk_rise_s;
    logic                   frame_edge_s;
    logic                   chan_match_s;
    logic [DATA_WIDTH-1:0]  next_word_s;

    assign bclk_s       = bclk_sync_r[SYNC_STAGES-1];
    assign lrck_s       = lrck_sync_r[SYNC_STAGES-1];
    assign sdata_s      = sdata_sync_r[SYNC_STAGES-1];
    assign bclk_rise_s  = bclk_s & ~bclk_d_r;
    assign frame_edge_s = bclk_rise_s & (lrck_s ^ lrck_prev_r);
    assign chan_match_s = (lrck_s == CHAN_LRCK);
    assign next_word_s  = {shift_r[DATA_WIDTH-2:0], sdata_s};

    // Input synchronisers, BCLK edge history and the word-select value of the last BCLK rise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bclk_sync_r  <= {SYNC_STAGES{1'b0}};
            lrck_sync_r  <= {SYNC_STAGES{1'b0}};
            sdata_sync_r <= {SYNC_STAGES{1'b0}};
            bclk_d_r     <= 1'b0;
            lrck_prev_r  <= 1'b0;
        end else begin
            bclk_sync_r  <= {bclk_sync_r[SYNC_STAGES-2:0], bclk};
            lrck_sync_r  <= {lrck_sync_r[SYNC_STAGES-2:0], lrck};
            sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], sdata};
            bclk_d_r     <= bclk_s;
            if (bclk_rise_s) begin
                lrck_prev_r <= lrck_s;
            end else begin
                lrck_prev_r <= lrck_prev_r;
            end
        end
    end

    // Capture FSM with the registered sample bus, strobe, counter and sticky error.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            bit_cnt_r       <= {CNT_W{1'b0}};
            shift_r         <= {DATA_WIDTH{1'b0}};
            data_out        <= {DATA_WIDTH{1'b0}};
            sample_valid    <= 1'b0;
            sample_count    <= 16'd0;
            short_frame_err <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            // A clear is issued first so an abort later in this block overrides it.
            if (clear_err) begin
                short_frame_err <= 1'b0;
            end else begin
                short_frame_err <= short_frame_err;
            end
            if (!enable) begin
                state_r   <= IDLE;
                bit_cnt_r <= {CNT_W{1'b0}};
            end else if (bclk_rise_s) begin
                case (state_r)
                    IDLE: begin
                        if (frame_edge_s && chan_match_s) begin
                            state_r <= DELAY;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DELAY: begin
                        if (frame_edge_s) begin
                            short_frame_err <= 1'b1;
                            state_r         <= chan_match_s ? DELAY : IDLE;
                        end else begin
                            state_r   <= SHIFT;
                            bit_cnt_r <= {CNT_W{1'b0}};
                        end
                    end
                    SHIFT: begin
                        if (frame_edge_s) begin
                            short_frame_err <= 1'b1;
                            state_r         <= chan_match_s ? DELAY : IDLE;
                        end else if (bit_cnt_r == LAST_BIT) begin
                            shift_r      <= next_word_s;
                            data_out     <= next_word_s;
                            sample_valid <= 1'b1;
                            sample_count <= sample_count + 16'd1;
                            state_r      <= IDLE;
                        end else begin
                            shift_r   <= next_word_s;
                            bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_capture.sv
// Bench for i2s_sample_capture: two instances (left and right channel) fed one I2S stream,
// checked every clock against a slot-level model plus hand-computed literal values.
module tb_i2s_sample_capture;

    localparam int KIND_RST  = 0;
    localparam int KIND_CLR  = 1;
    localparam int KIND_SET  = 2;
    localparam int KIND_CAP  = 3;
    localparam int KIND_LOAD = 4;
    // Raw BCLK rise driven at a negedge takes effect on the outputs three posedges later.
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b1;
    logic bclk = 1'b0;
    logic lrck = 1'b0;
    logic sdata = 1'b0;
    logic clear_err = 1'b0;

    logic [23:0] dout  [0:1];
    logic        valid [0:1];
    logic [15:0] cnt   [0:1];
    logic        err   [0:1];

    i2s_sample_capture #(.DATA_WIDTH(24), .CHANNEL(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bclk(bclk), .lrck(lrck),
        .sdata(sdata), .data_out(dout[0]), .sample_valid(valid[0]),
        .sample_count(cnt[0]), .short_frame_err(err[0]), .clear_err(clear_err));

    i2s_sample_capture #(.DATA_WIDTH(24), .CHANNEL(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bclk(bclk), .lrck(lrck),
        .sdata(sdata), .data_out(dout[1]), .sample_valid(valid[1]),
        .sample_count(cnt[1]), .short_frame_err(err[1]), .clear_err(clear_err));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int          at;
        int          kind;
        int          ch;
        logic [23:0] w;
    } ev_t;
    ev_t evq[$];

    logic [23:0] exp_data  [0:1];
    logic [15:0] exp_cnt   [0:1];
    logic        exp_valid [0:1];
    logic        exp_err   [0:1];
    bit          checking = 1'b0;

    bit          pending [0:1];
    logic [23:0] word    [0:1];
    logic        prev_l = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic void push_ev(input int at, input int kind, input int ch, input logic [23:0] w);
        ev_t e;
        e.at = at; e.kind = kind; e.ch = ch; e.w = w;
        evq.push_back(e);
    endfunction

    task automatic apply_ev(input ev_t e);
        case (e.kind)
            KIND_RST: begin
                for (int c = 0; c < 2; c++) begin
                    exp_data[c] = 24'd0; exp_cnt[c] = 16'd0;
                    exp_valid[c] = 1'b0; exp_err[c] = 1'b0;
                end
                checking = 1'b1;
            end
            KIND_CLR:  begin exp_err[0] = 1'b0; exp_err[1] = 1'b0; end
            KIND_SET:  exp_err[e.ch] = 1'b1;
            KIND_CAP:  begin
                exp_data[e.ch] = e.w; exp_valid[e.ch] = 1'b1;
                exp_cnt[e.ch] = exp_cnt[e.ch] + 16'd1;
            end
            KIND_LOAD: exp_cnt[e.ch] = 16'hFFFF;
            default:   ;
        endcase
    endtask

    // Per-cycle compare: apply events due at this posedge (clear before set), then check.
    always @(negedge clk) begin
        exp_valid[0] = 1'b0;
        exp_valid[1] = 1'b0;
        for (int k = 0; k < 5; k++)
            foreach (evq[i])
                if (evq[i].at == cyc && evq[i].kind == k) apply_ev(evq[i]);
        for (int i = evq.size() - 1; i >= 0; i--)
            if (evq[i].at <= cyc) evq.delete(i);
        if (checking) begin
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("data_out[ch%0d]", c), 32'(dout[c]), 32'(exp_data[c]));
                chk($sformatf("sample_valid[ch%0d]", c), 32'(valid[c]), 32'(exp_valid[c]));
                chk($sformatf("sample_count[ch%0d]", c), 32'(cnt[c]), 32'(exp_cnt[c]));
                chk($sformatf("short_frame_err[ch%0d]", c), 32'(err[c]), 32'(exp_err[c]));
            end
        end
    end

    // One I2S slot of nbits at BCLK = clk/8: two pad bits, then the word MSB first, then zeros.
    task automatic send_slot(input logic l, input logic [23:0] w, input int nbits,
                             input int dis_from, input int dis_to, input bit clr_edge);
        int rc;
        bit en_b, edge_b;
        for (int p = 0; p < nbits; p++) begin
            en_b = !(p >= dis_from && p < dis_to);
            @(negedge clk);
            bclk = 1'b0; lrck = l; enable = en_b;
            if (p < 2) sdata = 1'b1;
            else if (p <= 25) sdata = w[25 - p];
            else sdata = 1'b0;
            repeat (3) @(negedge clk);
            @(negedge clk);
            bclk = 1'b1;
            rc = cyc;
            edge_b = (p == 0) && (l != prev_l);
            prev_l = l;
            if (!en_b) begin
                pending[0] = 1'b0; pending[1] = 1'b0;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (edge_b && pending[c]) begin
                        pending[c] = 1'b0;
                        push_ev(rc + LAT, KIND_SET, c, 24'd0);
                    end
                    if (edge_b && int'(l) == c) begin
                        pending[c] = 1'b1; word[c] = w;
                    end else if (p == 25 && pending[c]) begin
                        push_ev(rc + LAT, KIND_CAP, c, word[c]);
                        pending[c] = 1'b0;
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (clr_edge && p == 0 && k == 1) begin
                    clear_err = 1'b1;
                    push_ev(cyc + 1, KIND_CLR, 0, 24'd0);
                end else begin
                    clear_err = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; bclk = 1'b0;
        push_ev(cyc + 1, KIND_RST, 0, 24'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pending[0] = 1'b0; pending[1] = 1'b0;
        prev_l = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        push_ev(cyc + 1, KIND_CLR, 0, 24'd0);
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pending[0] = 1'b0; pending[1] = 1'b0;
        do_reset();
        chk("reset data_out", 32'(dout[0]), 32'h0);
        chk("reset count", 32'(cnt[0]), 32'h0);

        // Normal stream: right first so the first left slot starts on a real edge.
        send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b0);
        chk("right word ch1", 32'(dout[1]), 32'h123456);
        chk("right count ch1", 32'(cnt[1]), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            send_slot(1'b0, 24'hA5C3F1, 32, 0, 0, 1'b0);
            chk("left word ch0", 32'(dout[0]), 32'hA5C3F1);
            chk("left count ch0", 32'(cnt[0]), 32'(k));
            send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b0);
            chk("ch0 ignores right", 32'(dout[0]), 32'hA5C3F1);
            chk("right count ch1", 32'(cnt[1]), 32'(k + 1));
        end

        // Short frame: 10 data bits of a left word after 0x111111.
        send_slot(1'b0, 24'h111111, 32, 0, 0, 1'b0);
        send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b0);
        send_slot(1'b0, 24'hABCDEF, 12, 0, 0, 1'b0);
        send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b0);
        chk("short err set", 32'(err[0]), 32'h1);
        chk("short data held", 32'(dout[0]), 32'h111111);
        send_slot(1'b0, 24'h7FFFFF, 32, 0, 0, 1'b0);
        chk("after short word", 32'(dout[0]), 32'h7FFFFF);

        // Clear coinciding with a new abort, then clear alone.
        send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b0);
        send_slot(1'b0, 24'hABCDEF, 12, 0, 0, 1'b0);
        send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b1);
        chk("set beats clear", 32'(err[0]), 32'h1);
        pulse_clear();
        chk("clear alone", 32'(err[0]), 32'h0);

        // Enable dropped mid-word, then a complete frame.
        send_slot(1'b0, 24'hABCDEF, 32, 10, 15, 1'b0);
        chk("disabled word dropped", 32'(dout[0]), 32'h7FFFFF);
        send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b0);
        chk("no err on disable", 32'(err[0]), 32'h0);
        send_slot(1'b0, 24'h000001, 32, 0, 0, 1'b0);
        chk("word after enable", 32'(dout[0]), 32'h000001);

        // Counter wrap from 0xFFFF.
        @(posedge clk);
        #2;
        force dut0.sample_count = 16'hFFFF;
        force dut1.sample_count = 16'hFFFF;
        push_ev(cyc, KIND_LOAD, 0, 24'd0);
        push_ev(cyc, KIND_LOAD, 1, 24'd0);
        #1;
        release dut0.sample_count;
        release dut1.sample_count;
        send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b0);
        chk("wrap ch1", 32'(cnt[1]), 32'h0);
        send_slot(1'b0, 24'h5A5A5A, 32, 0, 0, 1'b0);
        chk("wrap ch0", 32'(cnt[0]), 32'h0);
        chk("wrap word ch0", 32'(dout[0]), 32'h5A5A5A);

        // Reset mid-word with the error flag set.
        send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b0);
        send_slot(1'b0, 24'hABCDEF, 12, 0, 0, 1'b0);
        send_slot(1'b1, 24'h123456, 32, 0, 0, 1'b0);
        chk("err before reset", 32'(err[0]), 32'h1);
        send_slot(1'b0, 24'h333333, 12, 0, 0, 1'b0);
        do_reset();
        chk("reset data ch0", 32'(dout[0]), 32'h0);
        chk("reset data ch1", 32'(dout[1]), 32'h0);
        chk("reset err ch0", 32'(err[0]), 32'h0);
        chk("reset count ch1", 32'(cnt[1]), 32'h0);
        send_slot(1'b1, 24'h654321, 32, 0, 0, 1'b0);
        send_slot(1'b0, 24'h0F0F0F, 32, 0, 0, 1'b0);
        chk("post-reset ch0", 32'(dout[0]), 32'h0F0F0F);
        chk("post-reset ch1", 32'(dout[1]), 32'h654321);
        chk("post-reset count", 32'(cnt[0]), 32'd1);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
